// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its bus front end.
// Optional feature macro used by the target: I2C_TARGET_AUTOINC_EN.
package i2c_pkg;

    localparam int BYTE_BITS = 8;
    localparam int RW_BIT    = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEV_ADDR = 3'd1,
        ST_REG_ADDR = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_RD_DATA  = 3'd4
    } state_e;

    // ACK sub-phase: WAIT is between the 8th rising edge and the following
    // falling edge, SLOT is the 9th SCL low/high, POST is after the 9th rise.
    typedef enum logic [1:0] {
        PH_BITS     = 2'd0,
        PH_ACK_WAIT = 2'd1,
        PH_ACK_SLOT = 2'd2,
        PH_ACK_POST = 2'd3
    } phase_e;

    function automatic logic addr_match(input logic [7:0] rx, input logic [6:0] dev);
        return rx[7:1] == dev;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA and derives SCL edge pulses plus START/STOP pulses.
// Synchronizers reset to the idle-high bus level so reset never fakes an edge.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] scl_sync_q;
    logic [N-1:0] sda_sync_q;
    logic         scl_dly_q;
    logic         sda_dly_q;
    logic         scl_s;
    logic         sda_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[N-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[N-2:0], sda_i};
            scl_dly_q  <= scl_s;
            sda_dly_q  <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[N-1];
    assign sda_s = sda_sync_q[N-1];

    // SCL must be high on both sides of the SDA transition to qualify.
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_dly_q;
    assign scl_fall_o = ~scl_s & scl_dly_q;
    assign start_o    = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
    assign stop_o     = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target: device address, register address, then data bytes on a byte-wide
// register port. Define I2C_TARGET_AUTOINC_EN to auto-increment reg_addr.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_p;
    logic stop_p;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_p),
        .stop_o     (stop_p)
    );

    state_e     state_q,     state_d;
    phase_e     phase_q,     phase_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] shift_q,     shift_d;
    logic       drive_ack_q, drive_ack_d;
    logic       sda_oe_q,    sda_oe_d;
    logic [7:0] reg_addr_q,  reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       wr_en_q,     wr_en_d;
    logic       rd_en_q,     rd_en_d;
    logic       load_q,      load_d;
    logic       busy_q,      busy_d;
    logic [7:0] rx_byte;

    assign rx_byte = {shift_q[6:0], sda_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_BITS;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            drive_ack_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            drive_ack_q <= drive_ack_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        drive_ack_d = drive_ack_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        load_d      = rd_en_q;
        busy_d      = busy_q;

`ifdef I2C_TARGET_AUTOINC_EN
        // Step after the strobe so the sink sees the address of this byte.
        if (wr_en_q || rd_en_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end
`endif
        // Read data lands one clk after the sink registers the strobe.
        if (load_q) begin
            shift_d = reg_rdata;
        end

        if (start_p) begin
            state_d     = ST_DEV_ADDR;
            phase_d     = PH_BITS;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'd0;
            drive_ack_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else if (stop_p) begin
            state_d     = ST_IDLE;
            phase_d     = PH_BITS;
            bit_cnt_d   = 3'd0;
            drive_ack_d = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else if (state_q != ST_IDLE) begin
            case (phase_q)
                PH_BITS: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (state_q != ST_RD_DATA) begin
                            shift_d = rx_byte;
                        end
                        if (bit_cnt_q == 3'(BYTE_BITS - 1)) begin
                            phase_d     = PH_ACK_WAIT;
                            drive_ack_d = 1'b1;
                            case (state_q)
                                ST_DEV_ADDR: begin
                                    if (addr_match(rx_byte, DEV_ADDR)) begin
                                        busy_d  = 1'b1;
                                        state_d = rx_byte[RW_BIT] ? ST_RD_DATA : ST_REG_ADDR;
                                    end else begin
                                        state_d     = ST_IDLE;
                                        phase_d     = PH_BITS;
                                        drive_ack_d = 1'b0;
                                        busy_d      = 1'b0;
                                    end
                                end
                                ST_REG_ADDR: begin
                                    reg_addr_d = rx_byte;
                                    state_d    = ST_WR_DATA;
                                end
                                ST_WR_DATA: begin
                                    reg_wdata_d = rx_byte;
                                    wr_en_d     = 1'b1;
                                end
                                default: begin
                                    // Read byte done: the master owns the ACK slot.
                                    drive_ack_d = 1'b0;
                                end
                            endcase
                        end
                    end else if (scl_fall && state_q == ST_RD_DATA && bit_cnt_q != 3'd0) begin
                        sda_oe_d = ~shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                end
                PH_ACK_WAIT: begin
                    if (scl_fall) begin
                        sda_oe_d = drive_ack_q;
                        phase_d  = PH_ACK_SLOT;
                    end
                end
                PH_ACK_SLOT: begin
                    if (scl_rise) begin
                        phase_d = PH_ACK_POST;
                        if (state_q == ST_RD_DATA) begin
                            if (drive_ack_q || !sda_s) begin
                                rd_en_d = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                                phase_d = PH_BITS;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    if (scl_fall) begin
                        phase_d     = PH_BITS;
                        bit_cnt_d   = 3'd0;
                        drive_ack_d = 1'b0;
                        if (state_q == ST_RD_DATA) begin
                            sda_oe_d = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        sda_oe    = sda_oe_q;
        reg_addr  = reg_addr_q;
        reg_wdata = reg_wdata_q;
        reg_wr_en = wr_en_q;
        reg_rd_en = rd_en_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged bus master plus strobe monitors.
// Expectations that depend on I2C_TARGET_AUTOINC_EN follow the same macro.
module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] rdata = 8'hC3;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] wr_addr_log [0:15];
    logic [7:0] wr_data_log [0:15];
    logic [7:0] rd_addr_log [0:15];

    assign sda_bus = ~(m_low | sda_oe);

    always #5 clk = ~clk;

    i2c_target #(
        .DEV_ADDR    (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_rdata (rdata),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) begin
            wr_addr_log[wr_cnt[3:0]] <= reg_addr;
            wr_data_log[wr_cnt[3:0]] <= reg_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (reg_rd_en === 1'b1) begin
            rd_addr_log[rd_cnt[3:0]] <= reg_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        m_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q / 2);
        s = sda_bus;
        wait_clk(Q - Q / 2);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_low = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            b[i] = s;
        end
        bit_cycle(nack, s);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clk(3);
        if (sda_oe !== 1'b0) begin $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); miscompares++; end
        vectors++;
        if (reg_wr_en !== 1'b0) begin $display("FAIL reset_wr_en: got %b expected 0", reg_wr_en); miscompares++; end
        vectors++;
        if (reg_rd_en !== 1'b0) begin $display("FAIL reset_rd_en: got %b expected 0", reg_rd_en); miscompares++; end
        vectors++;
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy); miscompares++; end
        vectors++;
        if (reg_addr !== 8'h00) begin $display("FAIL reset_reg_addr: got %h expected 00", reg_addr); miscompares++; end
        vectors++;
        if (reg_wdata !== 8'h00) begin $display("FAIL reset_reg_wdata: got %h expected 00", reg_wdata); miscompares++; end
        vectors++;
        reset = 1'b0;
        wait_clk(4);
        $display("txn reset: outputs idle");
    endtask

    task automatic test_write();
        int w0, r0;
        logic a0, a1, a2;
        logic [7:0] exp_addr;
        w0 = wr_cnt;
        r0 = rd_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h10, a1);
        if (busy !== 1'b1) begin $display("FAIL write_busy_high: got %b expected 1", busy); miscompares++; end
        vectors++;
        send_byte(8'h5A, a2);
        i2c_stop();
        wait_clk(4);
`ifdef I2C_TARGET_AUTOINC_EN
        exp_addr = 8'h11;
`else
        exp_addr = 8'h10;
`endif
        if ({a0, a1, a2} !== 3'b111) begin $display("FAIL write_acks: got %b expected 111", {a0, a1, a2}); miscompares++; end
        vectors++;
        if (wr_cnt - w0 !== 1) begin $display("FAIL write_strobes: got %0d expected 1", wr_cnt - w0); miscompares++; end
        vectors++;
        if (wr_addr_log[w0[3:0]] !== 8'h10) begin $display("FAIL write_addr: got %h expected 10", wr_addr_log[w0[3:0]]); miscompares++; end
        vectors++;
        if (wr_data_log[w0[3:0]] !== 8'h5A) begin $display("FAIL write_data: got %h expected 5a", wr_data_log[w0[3:0]]); miscompares++; end
        vectors++;
        if (busy !== 1'b0) begin $display("FAIL write_busy_after_stop: got %b expected 0", busy); miscompares++; end
        vectors++;
        if (reg_addr !== exp_addr) begin $display("FAIL write_reg_addr_after: got %h expected %h", reg_addr, exp_addr); miscompares++; end
        vectors++;
        if (rd_cnt - r0 !== 0) begin $display("FAIL write_no_read: got %0d expected 0", rd_cnt - r0); miscompares++; end
        vectors++;
        $display("txn write: dev=50 reg=10 data=5a acks=%b", {a0, a1, a2});
    endtask

    task automatic test_mismatch();
        int w0, r0, o0;
        logic a0, a1;
        w0 = wr_cnt;
        r0 = rd_cnt;
        o0 = oe_cnt;
        i2c_start();
        send_byte(8'hA2, a0);
        send_byte(8'h10, a1);
        if (busy !== 1'b0) begin $display("FAIL mismatch_busy: got %b expected 0", busy); miscompares++; end
        vectors++;
        i2c_stop();
        wait_clk(4);
        if ({a0, a1} !== 2'b00) begin $display("FAIL mismatch_acks: got %b expected 00", {a0, a1}); miscompares++; end
        vectors++;
        if (oe_cnt - o0 !== 0) begin $display("FAIL mismatch_sda_oe: got %0d driven clks expected 0", oe_cnt - o0); miscompares++; end
        vectors++;
        if ((wr_cnt - w0) + (rd_cnt - r0) !== 0) begin $display("FAIL mismatch_strobes: got %0d expected 0", (wr_cnt - w0) + (rd_cnt - r0)); miscompares++; end
        vectors++;
        $display("txn mismatch: dev=51 acks=%b", {a0, a1});
    endtask

    task automatic test_read();
        int r0, w0;
        logic a0, a1, a2;
        logic [7:0] rb;
        r0 = rd_cnt;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h20, a1);
        i2c_start();
        send_byte(8'hA1, a2);
        recv_byte(1'b1, rb);
        if (busy !== 1'b0) begin $display("FAIL read_busy_after_nack: got %b expected 0", busy); miscompares++; end
        vectors++;
        if (sda_oe !== 1'b0) begin $display("FAIL read_sda_released: got %b expected 0", sda_oe); miscompares++; end
        vectors++;
        i2c_stop();
        wait_clk(4);
        if ({a0, a1, a2} !== 3'b111) begin $display("FAIL read_acks: got %b expected 111", {a0, a1, a2}); miscompares++; end
        vectors++;
        if (rb !== 8'hC3) begin $display("FAIL read_data: got %h expected c3", rb); miscompares++; end
        vectors++;
        if (rd_cnt - r0 !== 1) begin $display("FAIL read_strobes: got %0d expected 1", rd_cnt - r0); miscompares++; end
        vectors++;
        if (rd_addr_log[r0[3:0]] !== 8'h20) begin $display("FAIL read_addr: got %h expected 20", rd_addr_log[r0[3:0]]); miscompares++; end
        vectors++;
        if (wr_cnt - w0 !== 0) begin $display("FAIL read_no_write: got %0d expected 0", wr_cnt - w0); miscompares++; end
        vectors++;
        $display("txn read: reg=20 data=%h", rb);
    endtask

    task automatic test_autoinc();
        int w0;
        logic a0, a1, a2, a3;
        logic [7:0] exp2;
        w0 = wr_cnt;
`ifdef I2C_TARGET_AUTOINC_EN
        exp2 = 8'h00;
`else
        exp2 = 8'hFF;
`endif
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h01, a2);
        send_byte(8'h02, a3);
        i2c_stop();
        wait_clk(4);
        if ({a0, a1, a2, a3} !== 4'b1111) begin $display("FAIL autoinc_acks: got %b expected 1111", {a0, a1, a2, a3}); miscompares++; end
        vectors++;
        if (wr_cnt - w0 !== 2) begin $display("FAIL autoinc_strobes: got %0d expected 2", wr_cnt - w0); miscompares++; end
        vectors++;
        if (wr_addr_log[w0[3:0]] !== 8'hFF) begin $display("FAIL autoinc_addr0: got %h expected ff", wr_addr_log[w0[3:0]]); miscompares++; end
        vectors++;
        w0 = w0 + 1;
        if (wr_addr_log[w0[3:0]] !== exp2) begin $display("FAIL autoinc_addr1: got %h expected %h", wr_addr_log[w0[3:0]], exp2); miscompares++; end
        vectors++;
        if (wr_data_log[w0[3:0]] !== 8'h02) begin $display("FAIL autoinc_data1: got %h expected 02", wr_data_log[w0[3:0]]); miscompares++; end
        vectors++;
        $display("txn burst write: reg=ff data=01,02 second addr=%h", wr_addr_log[w0[3:0]]);
    endtask

    task automatic test_reset_mid();
        int w0;
        logic a0, a1, a2, s;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h30, a1);
        for (int i = 0; i < 4; i++) bit_cycle(1'b1, s);
        reset = 1'b1;
        wait_clk(1);
        if (sda_oe !== 1'b0) begin $display("FAIL rstmid_sda_oe: got %b expected 0", sda_oe); miscompares++; end
        vectors++;
        if (busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b expected 0", busy); miscompares++; end
        vectors++;
        if (reg_addr !== 8'h00) begin $display("FAIL rstmid_reg_addr: got %h expected 00", reg_addr); miscompares++; end
        vectors++;
        reset = 1'b0;
        m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        if (wr_cnt - w0 !== 0) begin $display("FAIL rstmid_no_write: got %0d expected 0", wr_cnt - w0); miscompares++; end
        vectors++;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h40, a1);
        send_byte(8'h77, a2);
        i2c_stop();
        wait_clk(4);
        if ({a0, a1, a2} !== 3'b111) begin $display("FAIL rstmid_acks: got %b expected 111", {a0, a1, a2}); miscompares++; end
        vectors++;
        if (wr_cnt - w0 !== 1) begin $display("FAIL rstmid_strobes: got %0d expected 1", wr_cnt - w0); miscompares++; end
        vectors++;
        if ({wr_addr_log[w0[3:0]], wr_data_log[w0[3:0]]} !== 16'h4077) begin $display("FAIL rstmid_write: got %h expected 4077", {wr_addr_log[w0[3:0]], wr_data_log[w0[3:0]]}); miscompares++; end
        vectors++;
        $display("txn reset mid-byte then write: reg=40 data=77");
    endtask

    task automatic test_stop_mid();
        int w0;
        logic a0, a1, s;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h50, a1);
        for (int i = 0; i < 5; i++) bit_cycle(1'b0, s);
        i2c_stop();
        wait_clk(4);
        if ({a0, a1} !== 2'b11) begin $display("FAIL stopmid_acks: got %b expected 11", {a0, a1}); miscompares++; end
        vectors++;
        if (wr_cnt - w0 !== 0) begin $display("FAIL stopmid_no_write: got %0d expected 0", wr_cnt - w0); miscompares++; end
        vectors++;
        if ({busy, sda_oe} !== 2'b00) begin $display("FAIL stopmid_idle: got busy/oe %b expected 00", {busy, sda_oe}); miscompares++; end
        vectors++;
        if (reg_addr !== 8'h50) begin $display("FAIL stopmid_reg_addr: got %h expected 50", reg_addr); miscompares++; end
        vectors++;
        $display("txn stop mid-byte: reg=50 no write");
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_autoinc();
        test_reset_mid();
        test_stop_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
